// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR of two operands, one SLICE-bit
// slice per clock, behind a start/busy/done handshake.
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("seq_logic_unit: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic [IW-1:0]    base;

  function automatic logic [SLICE-1:0] slice_f(input logic [1:0]       o,
                                               input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (o)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    out_d   = out_q;
    zero_d  = zero_q;
    base    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = in0;
          opb_d   = in1;
          op_d    = op;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        base = IW'(int'(cnt_q) * SLICE);
        acc_d[base +: SLICE] = slice_f(op_q, opa_q[base +: SLICE], opb_q[base +: SLICE]);
        cnt_d = cnt_q + 1'b1;
        // Final slice: publish the accumulator including the slice written this edge.
        if (cnt_q == LAST) begin
          out_d   = acc_d;
          zero_d  = (acc_d == '0);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign out  = out_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed bench for seq_logic_unit: default 8-bit-slice build plus a single-slice build.
module tb_seq_logic_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start1;
  logic [1:0]  op, op1;
  logic [31:0] in0, in1, a1, b1;
  logic        busy, done, zero, busy1, done1, zero1;
  logic [31:0] out, out1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in0(in0), .in1(in1),
    .busy(busy), .done(done), .out(out), .zero(zero)
  );

  seq_logic_unit #(.WIDTH(32), .SLICE(32)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .in0(a1), .in1(b1),
    .busy(busy1), .done(done1), .out(out1), .zero(zero1)
  );

  // Drive a start for one edge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; in0 = a; in1 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles (bounded) and notes whether out moved or busy/done overlapped.
  task automatic wait_run(output int cycles, output logic moved, output logic overlap);
    logic [31:0] held;
    held = out; cycles = 0; moved = 1'b0; overlap = 1'b0;
    while (busy && cycles < 20) begin
      if (out !== held) moved = 1'b1;
      if (busy && done) overlap = 1'b1;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; start1 = 0; op = 0; op1 = 0; in0 = 0; in1 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (out !== 32'h0) begin bad++; $display("FAIL rst_out got=%h want=0", out); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b want=1", zero); end
    total++; if (zero1 !== 1'b1 || out1 !== 32'h0) begin bad++; $display("FAIL rst_dut1 got=%b/%h want=1/0", zero1, out1); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL idle_after_rst got=%b%b want=00", busy, done); end
  endtask

  task automatic test_and();
    int c; logic mv, ov;
    issue(2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF);
    wait_run(c, mv, ov);
    total++; if (c != 4) begin bad++; $display("FAIL and_busy_cycles got=%0d want=4", c); end
    total++; if (mv !== 1'b0) begin bad++; $display("FAIL and_out_stable got=%b want=0", mv); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL and_busy_done_overlap got=%b want=0", ov); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL and_done got=%b want=1", done); end
    total++; if (out !== 32'h00F0_1234) begin bad++; $display("FAIL and_out got=%h want=00f01234", out); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL and_zero got=%b want=0", zero); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL and_done_pulse got=%b%b want=00", done, busy); end
  endtask

  task automatic test_or();
    int c; logic mv, ov;
    issue(2'b01, 32'h1234_0000, 32'h0000_5678);
    wait_run(c, mv, ov);
    total++; if (c != 4 || done !== 1'b1) begin bad++; $display("FAIL or_timing got=%0d/%b want=4/1", c, done); end
    total++; if (out !== 32'h1234_5678) begin bad++; $display("FAIL or_out got=%h want=12345678", out); end
    total++; if (mv !== 1'b0) begin bad++; $display("FAIL or_out_stable got=%b want=0", mv); end
  endtask

  task automatic test_nor_xor();
    int c; logic mv, ov;
    issue(2'b11, 32'hFFFF_0000, 32'h0000_00FF);
    wait_run(c, mv, ov);
    total++; if (out !== 32'h0000_FF00) begin bad++; $display("FAIL nor_out got=%h want=0000ff00", out); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL nor_zero got=%b want=0", zero); end
    issue(2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wait_run(c, mv, ov);
    total++; if (c != 4 || done !== 1'b1) begin bad++; $display("FAIL xor_timing got=%0d/%b want=4/1", c, done); end
    total++; if (out !== 32'h0) begin bad++; $display("FAIL xor_out got=%h want=0", out); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL xor_zero got=%b want=1", zero); end
  endtask

  task automatic test_ignored();
    int c; logic mv, ov;
    issue(2'b00, 32'hAAAA_5555, 32'hFFFF_0F0F);
    start = 1'b1; op = 2'b01; in0 = 32'hFFFF_FFFF; in1 = 32'hFFFF_FFFF;
    wait_run(c, mv, ov);
    total++; if (c != 4 || done !== 1'b1) begin bad++; $display("FAIL ign_timing got=%0d/%b want=4/1", c, done); end
    total++; if (out !== 32'hAAAA_0505) begin bad++; $display("FAIL ign_out got=%h want=aaaa0505", out); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_start_in_done got=%b want=0", busy); end
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ign_idle got=%b%b want=00", busy, done); end
  endtask

  task automatic test_reset_mid();
    int c; logic mv, ov; logic seen;
    issue(2'b10, 32'h1234_5678, 32'h0000_0000);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=%b%b want=00", busy, done); end
    total++; if (out !== 32'h0 || zero !== 1'b1) begin bad++; $display("FAIL mid_rst_out got=%h/%b want=0/1", out, zero); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_done got=%b want=0", seen); end
    issue(2'b01, 32'h0F0F_0000, 32'h0000_F0F0);
    wait_run(c, mv, ov);
    total++; if (c != 4 || out !== 32'h0F0F_F0F0) begin bad++; $display("FAIL mid_rst_new_op got=%0d/%h want=4/0f0ff0f0", c, out); end
  endtask

  task automatic test_back_to_back();
    int c; logic mv, ov;
    issue(2'b10, 32'hFFFF_0000, 32'h0F0F_0F0F);
    wait_run(c, mv, ov);
    total++; if (out !== 32'hF0F0_0F0F) begin bad++; $display("FAIL b2b_first got=%h want=f0f00f0f", out); end
    start = 1'b1; op = 2'b00; in0 = 32'hFFFF_FFFF; in1 = 32'h1234_5678;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b want=0", busy); end
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    wait_run(c, mv, ov);
    total++; if (c != 4 || out !== 32'h1234_5678) begin bad++; $display("FAIL b2b_second got=%0d/%h want=4/12345678", c, out); end
  endtask

  task automatic test_single_slice();
    @(negedge clk);
    start1 = 1'b1; op1 = 2'b00; a1 = 32'hFFFF_FFFF; b1 = 32'h8000_0001;
    @(negedge clk);
    start1 = 1'b0;
    total++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin bad++; $display("FAIL ss_run got=%b%b want=10", busy1, done1); end
    @(negedge clk);
    total++; if (busy1 !== 1'b0 || done1 !== 1'b1) begin bad++; $display("FAIL ss_done got=%b%b want=01", busy1, done1); end
    total++; if (out1 !== 32'h8000_0001 || zero1 !== 1'b0) begin bad++; $display("FAIL ss_out got=%h/%b want=80000001/0", out1, zero1); end
    @(negedge clk);
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL ss_pulse got=%b want=0", done1); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_or();
    test_nor_xor();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_single_slice();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_logic_unit.md
Name: seq_logic_unit

Overview:
- Multi-cycle bitwise logic unit for the ALU datapath.
- Computes AND/OR/XOR/NOR of two 32-bit operands, one SLICE-bit slice per clock.
- Uses a start/busy/done handshake, so it can replace wide combinational gates on area-constrained builds.
- Sits beside the combinational bitwise gates; the ALU result mux selects `out` when `done` is high.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per RUN cycle. WIDTH % SLICE must be 0. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR
- in0  input  WIDTH  operand A, captured on accepted start
- in1  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while an operation is in progress (RUN)
- done  output  1  one-cycle pulse: `out` has just been updated
- out  output  WIDTH  result register; holds the last completed result
- zero  output  1  registered flag, out == 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset=1: state=IDLE, busy=0, done=0, out=0, zero=1, slice counter=0, operand/op/accumulator registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: capture in0, in1, op into internal registers; counter=0; go to RUN (busy=1 from the next cycle).
  - start=0: stay in IDLE.
- RUN, each edge:
  - Compute accumulator[cnt*SLICE +: SLICE] = f(opA slice, opB slice, op); cnt++.
  - NOR is the per-bit inverse of OR.
  - When the edge processes cnt == NSLICE-1: copy the full accumulator, including the slice written this edge, to `out`; update `zero`; go to DONE.
- DONE: busy=0, done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: start accepted at edge T0 -> busy high T0..T(NSLICE) -> out/zero updated and done high after edge T(NSLICE). Default is 4 cycles after the accepting edge.
- Back-to-back: start is ignored in the DONE cycle. Earliest next accept is the first IDLE cycle, giving a throughput of one op per NSLICE+2 cycles.
- Inputs after capture: start, in0, in1, op are ignored while busy or in DONE; changing them mid-operation does not affect the result.
- out stability: out holds its previous value for the whole of RUN and changes only on the RUN->DONE edge.
- Degenerate width: with SLICE == WIDTH, RUN lasts exactly 1 cycle.
- Reset mid-operation: immediate abort to the reset values above. No done pulse; the partial result is discarded.
- Invariant: busy and done are never high together.
- No X propagation: op is fully decoded, with no default-to-X.

Test Plan:
- AND: reset, then start with op=00, in0=0xF0F0_1234, in1=0x0FF0_FFFF -> busy high 4 cycles; done pulses 1 cycle; out=0x00F0_1234, zero=0.
- OR: op=01, in0=0x1234_0000, in1=0x0000_5678 -> out=0x1234_5678.
- NOR, then XOR:
  - NOR: op=11, in0=0xFFFF_0000, in1=0x0000_00FF -> out=0x0000_FF00, zero=0.
  - XOR: op=10, in0=in1=0xDEAD_BEEF -> out=0, zero=1.
- Ignored inputs: start pulsed again and in0/in1/op changed mid-RUN -> original result delivered. No second operation starts; next accept only in IDLE after done.
- Reset mid-operation: reset asserted asynchronously 2 cycles into RUN (not edge-aligned) -> busy=0, done=0, out=0, zero=1 immediately; no done pulse afterward. A new op after reset completes correctly.
- Single-slice build: SLICE=32, AND of 0xFFFF_FFFF and 0x8000_0001 -> busy 1 cycle; out=0x8000_0001 after the accepting edge +1.
